// File: rtl/bus_request_arbiter.sv
// Round-robin arbiter sharing one req/aack/wack/rack target bus among NREQ requesters.
// Define BUS_ARB_TIMEOUT_EN to enable the per-phase timeout (TIMEOUT_CYCLES); otherwise the FSM waits indefinitely.
module bus_request_arbiter #(
    parameter int NREQ           = 4,
    parameter int AWIDTH         = 8,
    parameter int DWIDTH         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ-1:0]        i_readWrite_n,
    input  logic [NREQ*AWIDTH-1:0] i_addr,
    input  logic [NREQ*DWIDTH-1:0] i_wdata,
    output logic [NREQ-1:0]        o_addressAck,
    output logic [NREQ-1:0]        o_writeAck,
    output logic [NREQ-1:0]        o_readAck,
    output logic [NREQ-1:0]        o_grant,
    output logic                   o_req,
    output logic                   o_readWrite_n,
    output logic [AWIDTH-1:0]      o_addr,
    output logic [DWIDTH-1:0]      o_wdata,
    input  logic                   i_addressAck,
    input  logic                   i_writeAck,
    input  logic                   i_readAck,
    output logic                   o_timeout
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("bus_request_arbiter: NREQ must be 2..16 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t          state;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   rr_ptr;
    logic            rnw_latched;

    logic [IW-1:0]   next_idx;
    logic [IW-1:0]   after_idx;
    logic            any_req;
    logic            addr_phase;
    logic            data_phase;
    logic            data_match;
    logic            fwd_data;
    logic            phase_done;
    logic            to_data;
    logic            timeout_hit;

    // First requesting index at or after the round-robin pointer, wrapping at NREQ.
    always_comb begin
        any_req  = 1'b0;
        next_idx = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && i_req[(int'(rr_ptr) + k) % NREQ]) begin
                any_req  = 1'b1;
                next_idx = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign after_idx  = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign addr_phase = (state == ST_ADDR);
    assign data_phase = (state == ST_DATA);
    assign data_match = rnw_latched ? i_readAck : i_writeAck;

    // A data ack arriving together with the address ack completes the transaction in one step.
    assign fwd_data   = (addr_phase && i_addressAck && data_match) || (data_phase && data_match);
    assign phase_done = fwd_data || timeout_hit;
    assign to_data    = addr_phase && i_addressAck && !data_match;

    assign o_grant       = grant;
    assign o_req         = addr_phase;
    assign o_readWrite_n = addr_phase & rnw_latched;
    assign o_addr        = addr_phase ? i_addr[grant_idx*AWIDTH +: AWIDTH] : '0;
    assign o_wdata       = addr_phase ? i_wdata[grant_idx*DWIDTH +: DWIDTH] : '0;
    assign o_addressAck  = (addr_phase && i_addressAck) ? grant : '0;
    assign o_readAck     = (fwd_data && rnw_latched) ? grant : '0;
    assign o_writeAck    = (fwd_data && !rnw_latched) ? grant : '0;
    assign o_timeout     = timeout_hit;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] phase_cnt;
    logic          qual_ack;

    assign qual_ack    = addr_phase ? i_addressAck : data_match;
    assign timeout_hit = (addr_phase || data_phase) && !qual_ack
                         && (phase_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Held at zero while idle so it starts from zero on entry to ADDR; restarted on entry to DATA.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            phase_cnt <= '0;
        end else if (state == ST_IDLE || to_data || phase_done) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            rr_ptr      <= '0;
            rnw_latched <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state       <= ST_ADDR;
                        grant       <= NREQ'(1) << next_idx;
                        grant_idx   <= next_idx;
                        rnw_latched <= i_readWrite_n[next_idx];
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (phase_done) begin
                        state  <= ST_IDLE;
                        grant  <= '0;
                        rr_ptr <= after_idx;
                    end else if (to_data) begin
                        state <= ST_DATA;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Self-checking bench for bus_request_arbiter: directed spec scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_bus_request_arbiter;
    localparam int NREQ           = 4;
    localparam int AWIDTH         = 8;
    localparam int DWIDTH         = 8;
    localparam int TIMEOUT_CYCLES = 4;

    logic                   i_clk = 1'b0;
    logic                   i_arst;
    logic [NREQ-1:0]        i_req;
    logic [NREQ-1:0]        i_readWrite_n;
    logic [NREQ*AWIDTH-1:0] i_addr;
    logic [NREQ*DWIDTH-1:0] i_wdata;
    logic [NREQ-1:0]        o_addressAck;
    logic [NREQ-1:0]        o_writeAck;
    logic [NREQ-1:0]        o_readAck;
    logic [NREQ-1:0]        o_grant;
    logic                   o_req;
    logic                   o_readWrite_n;
    logic [AWIDTH-1:0]      o_addr;
    logic [DWIDTH-1:0]      o_wdata;
    logic                   i_addressAck;
    logic                   i_writeAck;
    logic                   i_readAck;
    logic                   o_timeout;

    logic [AWIDTH-1:0] req_addr  [NREQ];
    logic [DWIDTH-1:0] req_wdata [NREQ];

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the bus, which phase, the rotation pointer.
    bit m_busy  = 1'b0;
    bit m_data  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    bit m_rnw   = 1'b0;
    int m_cnt   = 0;

    logic [NREQ-1:0] seen_aack = '0;

    bus_request_arbiter #(
        .NREQ(NREQ), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_req(i_req), .i_readWrite_n(i_readWrite_n),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_addressAck(o_addressAck),
        .o_writeAck(o_writeAck), .o_readAck(o_readAck), .o_grant(o_grant), .o_req(o_req),
        .o_readWrite_n(o_readWrite_n), .o_addr(o_addr), .o_wdata(o_wdata),
        .i_addressAck(i_addressAck), .i_writeAck(i_writeAck), .i_readAck(i_readAck),
        .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    always_comb begin
        i_addr  = '0;
        i_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            i_addr[k*AWIDTH +: AWIDTH]  = req_addr[k];
            i_wdata[k*DWIDTH +: DWIDTH] = req_wdata[k];
        end
    end

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput();
        logic [NREQ-1:0] e_grant, e_aack, e_wack, e_rack;
        bit e_req, e_to, match, qual;
        e_grant = '0; e_aack = '0; e_wack = '0; e_rack = '0;
        e_req = 1'b0; e_to = 1'b0; qual = 1'b0;
        if (i_arst) begin
            checkValue("rst_addr", o_addr, 0);
            checkValue("rst_wdata", o_wdata, 0);
            checkValue("rst_rnw", o_readWrite_n, 0);
        end else if (m_busy) begin
            match   = m_rnw ? i_readAck : i_writeAck;
            e_grant = NREQ'(1) << m_owner;
            if (!m_data) begin
                e_req = 1'b1;
                qual  = i_addressAck;
                if (i_addressAck) e_aack = e_grant;
                if (i_addressAck && match) begin
                    if (m_rnw) e_rack = e_grant; else e_wack = e_grant;
                end
                checkValue("m_addr", o_addr, req_addr[m_owner]);
                checkValue("m_wdata", o_wdata, req_wdata[m_owner]);
                checkValue("m_rnw", o_readWrite_n, m_rnw);
            end else begin
                qual = match;
                if (match) begin
                    if (m_rnw) e_rack = e_grant; else e_wack = e_grant;
                end
            end
`ifdef BUS_ARB_TIMEOUT_EN
            e_to = !qual && (m_cnt == TIMEOUT_CYCLES - 1);
`endif
        end
        checkValue("m_grant", o_grant, e_grant);
        checkValue("m_req", o_req, e_req);
        checkValue("m_aack", o_addressAck, e_aack);
        checkValue("m_wack", o_writeAck, e_wack);
        checkValue("m_rack", o_readAck, e_rack);
        checkValue("m_timeout", o_timeout, e_to);
    endtask

    task automatic modelStep();
        bit match, qual, done;
        if (i_arst) begin
            m_busy = 1'b0; m_data = 1'b0; m_ptr = 0; m_rnw = 1'b0; m_cnt = 0;
            return;
        end
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (!m_busy && i_req[c]) begin
                    m_busy = 1'b1; m_data = 1'b0; m_owner = c;
                    m_rnw = i_readWrite_n[c]; m_cnt = 0;
                end
            end
        end else begin
            match = m_rnw ? i_readAck : i_writeAck;
            qual  = m_data ? match : i_addressAck;
            done  = m_data ? match : (i_addressAck && match);
`ifdef BUS_ARB_TIMEOUT_EN
            if (!qual && m_cnt == TIMEOUT_CYCLES - 1) done = 1'b1;
`endif
            if (done) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % NREQ;
            end else if (!m_data && i_addressAck) begin
                m_data = 1'b1;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    always @(negedge i_clk) begin
        checkOutput();
        modelStep();
        seen_aack = o_addressAck;
    end

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ-1:0] rnw,
                                 input logic aack, input logic wack, input logic rack);
        i_req = req; i_readWrite_n = rnw;
        i_addressAck = aack; i_writeAck = wack; i_readAck = rack;
    endtask

    task automatic stepCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog expired before end of test");
        summary();
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [NREQ-1:0] exp_grant;
        bit holding [NREQ];
        i_arst = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            req_addr[k]  = AWIDTH'($urandom);
            req_wdata[k] = DWIDTH'($urandom);
            holding[k]   = 1'b0;
        end
        applyStimulus('1, '0, 1'b1, 1'b1, 1'b1);

        // Reset holds every output at zero even with all requests and acks high.
        @(negedge i_clk);
        checkValue("reset_grant", o_grant, 0);
        checkValue("reset_req", o_req, 0);
        checkValue("reset_aack", o_addressAck, 0);
        checkValue("reset_wack", o_writeAck, 0);
        checkValue("reset_rack", o_readAck, 0);
        checkValue("reset_timeout", o_timeout, 0);
        stepCycle();
        applyStimulus('1, '0, 1'b0, 1'b0, 1'b0);
        i_arst = 1'b0;
        stepCycle();
        @(negedge i_clk);
        checkValue("post_reset_grant", o_grant, 4'b0001);
        checkValue("post_reset_req", o_req, 1);
        stepCycle();
        applyStimulus('1, '0, 1'b1, 1'b1, 1'b0);
        @(negedge i_clk);
        checkValue("post_reset_aack", o_addressAck, 4'b0001);
        checkValue("post_reset_wack", o_writeAck, 4'b0001);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();

        // Single write on requester 2 (pointer is now 1).
        req_addr[2] = 8'h5A; req_wdata[2] = 8'hC3;
        applyStimulus(4'b0100, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        @(negedge i_clk);
        checkValue("wr_grant", o_grant, 4'b0100);
        checkValue("wr_addr", o_addr, 8'h5A);
        checkValue("wr_wdata", o_wdata, 8'hC3);
        checkValue("wr_rnw", o_readWrite_n, 0);
        stepCycle();
        applyStimulus(4'b0100, '0, 1'b1, 1'b0, 1'b0);
        @(negedge i_clk);
        checkValue("wr_aack", o_addressAck, 4'b0100);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        checkValue("wr_data_req", o_req, 0);
        checkValue("wr_data_grant", o_grant, 4'b0100);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge i_clk);
        checkValue("wr_wack", o_writeAck, 4'b0100);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        checkValue("wr_idle_grant", o_grant, 0);

        // Fairness from a fresh pointer.
        stepCycle();
        i_arst = 1'b1;
        stepCycle();
        i_arst = 1'b0;
        applyStimulus('1, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            for (int w = 0; w < 10 && o_grant == '0; w++) @(negedge i_clk);
            exp_grant = NREQ'(1) << (k % NREQ);
            checkValue($sformatf("fair_grant_%0d", k), o_grant, exp_grant);
            stepCycle();
            applyStimulus('1, '0, 1'b1, 1'b1, 1'b0);
            stepCycle();
            applyStimulus('1, '0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();

        // Read on requester 1: a stray write ack in DATA is ignored.
        applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0);
        @(negedge i_clk);
        checkValue("rd_aack", o_addressAck, 4'b0010);
        checkValue("rd_rnw", o_readWrite_n, 1);
        checkValue("rd_early_rack", o_readAck, 0);
        stepCycle();
        applyStimulus('0, 4'b0010, 1'b0, 1'b1, 1'b0);
        @(negedge i_clk);
        checkValue("rd_wrong_wack", o_writeAck, 0);
        checkValue("rd_wrong_grant", o_grant, 4'b0010);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge i_clk);
        checkValue("rd_rack", o_readAck, 4'b0010);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        checkValue("rd_idle_grant", o_grant, 0);

        // Address and read ack together in ADDR on requester 3.
        applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1);
        @(negedge i_clk);
        checkValue("same_aack", o_addressAck, 4'b1000);
        checkValue("same_rack", o_readAck, 4'b1000);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        checkValue("same_idle_grant", o_grant, 0);
        checkValue("same_idle_req", o_req, 0);

`ifdef BUS_ARB_TIMEOUT_EN
        applyStimulus(4'b0011, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        for (int c = 1; c <= TIMEOUT_CYCLES; c++) begin
            @(negedge i_clk);
            checkValue($sformatf("to_pulse_%0d", c), o_timeout, (c == TIMEOUT_CYCLES));
            checkValue($sformatf("to_aack_%0d", c), o_addressAck, 0);
            stepCycle();
        end
        @(negedge i_clk);
        checkValue("to_idle_grant", o_grant, 0);
        stepCycle();
        @(negedge i_clk);
        checkValue("to_next_grant", o_grant, 4'b0010);
`else
        applyStimulus(4'b0001, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        for (int c = 0; c < 110; c++) stepCycle();
        @(negedge i_clk);
        checkValue("stall_grant", o_grant, 4'b0001);
        checkValue("stall_req", o_req, 1);
        checkValue("stall_timeout", o_timeout, 0);
`endif
        applyStimulus('0, '0, 1'b1, 1'b1, 1'b0);
        stepCycle();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        stepCycle();

        // Randomized traffic: requesters hold until their address ack, acks arrive at random.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stepCycle();
            if (i_arst) begin
                i_arst = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                i_arst = 1'b1;
                for (int k = 0; k < NREQ; k++) holding[k] = 1'b0;
            end
            for (int k = 0; k < NREQ; k++) begin
                if (holding[k] && seen_aack[k]) holding[k] = 1'b0;
                if (!holding[k] && !i_arst && $urandom_range(0, 3) == 0) begin
                    holding[k]       = 1'b1;
                    req_addr[k]      = AWIDTH'($urandom);
                    req_wdata[k]     = DWIDTH'($urandom);
                    i_readWrite_n[k] = 1'($urandom_range(0, 1));
                end
                i_req[k] = holding[k];
            end
            i_addressAck = ($urandom_range(0, 2) == 0);
            i_writeAck   = ($urandom_range(0, 3) == 0);
            i_readAck    = ($urandom_range(0, 3) == 0);
        end

        stepCycle();
        summary();
        $finish;
    end

endmodule
